sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter: WIDTH, 8, number of serial bits per parallel word (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: s_valid  input  1  qualifies s_in on the current edge.
REQ-005 SHALL have port: s_in  input  1  serial data, LSB of each word first.
REQ-006 SHALL have port: flush  input  1  aborts the partially collected word.
REQ-007 SHALL have port: p_out  output  WIDTH  assembled parallel word.
REQ-008 SHALL have port: p_valid  output  1  p_out holds an unconsumed word.
REQ-009 SHALL have port: p_ready  input  1  consumer accepts p_out on this edge.
REQ-010 SHALL have port: overflow  output  1  sticky flag; a completed word was dropped.

Function
REQ-011 SHALL shift into a WIDTH-bit shift register on each edge with s_valid=1: shreg <= {s_in, shreg[WIDTH-1:1]}, so the first bit received lands in bit 0.
REQ-012 SHALL keep a bit counter, 0..WIDTH-1, incremented on each edge with s_valid=1 and wrapping to 0 after the WIDTH-th bit.
REQ-013 SHALL treat an edge with s_valid=1 and counter=WIDTH-1 as word completion; the completed word is {s_in, shreg[WIDTH-1:1]}.
REQ-014 SHALL hold and not shift the shift register or counter on edges with s_valid=0.
REQ-015 SHALL use an output holding stage with two states, EMPTY (p_valid=0) and FULL (p_valid=1).
REQ-016 SHALL move EMPTY->FULL on word completion; p_out and p_valid update on that same edge, one cycle after the last bit is sampled (latency 1).
REQ-017 SHALL move FULL->EMPTY on an edge with p_valid=1, p_ready=1 and no word completion.
REQ-018 SHALL stay FULL and load the new word into p_out when completion and p_valid&&p_ready fall on the same edge.
REQ-019 SHALL discard the new word on completion while FULL without p_ready; p_out is kept and overflow is set to 1.
REQ-020 SHALL hold p_out stable while p_valid=1 and p_ready=0.
REQ-021 SHALL ignore p_ready while EMPTY.
REQ-022 SHALL, on flush=1, clear the shift register and counter to 0, discard any s_valid bit on that edge, and leave the holding stage and overflow untouched.
REQ-023 SHALL keep overflow at 1 once set, until reset.
REQ-024 SHALL provide no-bubble streaming: back-to-back words with s_valid continuously 1 and p_ready continuously 1 are all delivered with no overflow.

Reset
REQ-025 SHALL, on reset=1 at an edge, set shift register=0, counter=0, holding state=EMPTY, p_out=0, p_valid=0 and overflow=0.
REQ-026 SHALL give reset priority over flush, s_valid and p_ready, and discard any partial word in progress.
REQ-027 SHALL count the first s_valid bit after reset deasserts as bit 0 of a new word.

Structure
REQ-028 SHALL place in package sipo_pkg: default WIDTH constant, counter-width constant ($clog2(WIDTH)), and the holding-state enum typedef (EMPTY, FULL).
REQ-029 SHALL implement the bit counter as sub-module bit_counter, parameterised by modulus, with ports clk, reset, clr, en, count and wrap.
REQ-030 SHALL keep all sequential logic in always_ff blocks clocked by clk only, with no latches or combinational loops.

Verification
REQ-031 SHALL cover: reset, then bits 1,0,1,0,0,1,0,1 with s_valid=1 and p_ready=0 -> p_valid=1 one cycle after the 8th bit, p_out=8'hA5, overflow=0.
REQ-032 SHALL cover: 3 bits sent, flush=1 for one cycle, then 8'h3C sent LSB first -> p_out=8'h3C and no corruption from the flushed bits.
REQ-033 SHALL cover: 8'h11 completes, p_ready held 0, 8'h22 completes -> p_out stays 8'h11 and overflow=1; then p_ready=1 -> p_valid=0 next cycle.
REQ-034 SHALL cover: continuous s_valid with p_ready=1 streaming 8'h01, 8'h02, 8'h03 -> three p_valid pulses in that order, overflow=0.
REQ-035 SHALL cover: completion of 8'hF0 on the same edge as consumption of 8'h0F -> p_valid stays 1, p_out=8'hF0, overflow=0.
REQ-036 SHALL cover: reset asserted after bit 5 of a word, then 8'h81 sent -> p_out=8'h81 with no stale bits.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and types for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/sipo_deser_bit_counter.sv
// Modulo-N bit counter; wrap flags the edge on which the last count is consumed.
module bit_counter #(
    parameter int MODULUS = 8,
    localparam int CW = $clog2(MODULUS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(MODULUS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign wrap  = en && (count_q == MAX_COUNT);
    assign count = count_q;

    // Clear beats enable so an aborted word restarts from bit 0.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with a one-word holding stage and sticky overflow.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic             s_in,
    input  logic             flush,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] pout_q;
    logic [WIDTH-1:0] pout_d;
    logic             ovf_q;
    logic             ovf_d;
    hold_state_e      state_q;
    hold_state_e      state_d;

    logic             advance;
    logic             wordDone;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    bitCount;

    assign advance = s_valid && !flush;
    assign word    = {s_in, shreg_q[WIDTH-1:1]};

    bit_counter #(
        .MODULUS(WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (flush),
        .en   (advance),
        .count(bitCount),
        .wrap (wordDone)
    );

    always_comb begin
        shreg_d = shreg_q;
        if (flush) begin
            shreg_d = '0;
        end else if (s_valid) begin
            shreg_d = word;
        end
    end

    // A completed word always wins over consumption; it is only dropped when nobody is taking the held one.
    always_comb begin
        state_d = state_q;
        pout_d  = pout_q;
        ovf_d   = ovf_q;
        case (state_q)
            EMPTY: begin
                if (wordDone) begin
                    state_d = FULL;
                    pout_d  = word;
                end
            end
            FULL: begin
                if (wordDone) begin
                    if (p_ready) begin
                        pout_d = word;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (p_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            pout_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= EMPTY;
        end else begin
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign p_out    = pout_q;
    assign p_valid  = (state_q == FULL);
    assign overflow = ovf_q;

    wrapConsistent: assert property (@(posedge clk) disable iff (reset)
        wordDone |-> (bitCount == CW'(WIDTH - 1)));

endmodule

// File: tb/tb_sipo_deser.sv
// Directed table plus hand-written sequences for the sipo_deser corner cases.
module tb_sipo_deser;

    logic       clk;
    logic       reset;
    logic       s_valid;
    logic       s_in;
    logic       flush;
    logic [7:0] p_out;
    logic       p_valid;
    logic       p_ready;
    logic       overflow;

    int assertCount = 0;
    int failCount   = 0;

    sipo_deser #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_in    (s_in),
        .flush   (flush),
        .p_out   (p_out),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       sv;
        logic       si;
        logic       fl;
        logic       rdy;
        logic       expValid;
        logic       chkData;
        logic [7:0] expOut;
        logic       expOvf;
    } vec_t;

    vec_t vecs[11];

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic sv, input logic si,
                                 input logic fl, input logic rdy);
        @(negedge clk);
        reset   = rst;
        s_valid = sv;
        s_in    = si;
        flush   = fl;
        p_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expValid, input logic chkData,
                               input logic [7:0] expOut, input logic expOvf);
        assertCount++;
        if (p_valid !== expValid) begin
            failCount++;
            $display("[TB] FAIL %s p_valid: got %b, expected %b", name, p_valid, expValid);
        end
        assertCount++;
        if (overflow !== expOvf) begin
            failCount++;
            $display("[TB] FAIL %s overflow: got %b, expected %b", name, overflow, expOvf);
        end
        if (chkData) begin
            assertCount++;
            if (p_out !== expOut) begin
                failCount++;
                $display("[TB] FAIL %s p_out: got %h, expected %h", name, p_out, expOut);
            end
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic rdy);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, b[i], 1'b0, rdy);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset", 1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_in    = 1'b0;
        flush   = 1'b0;
        p_ready = 1'b0;

        // Bits 1,0,1,0,0,1,0,1 LSB first assemble 8'hA5; then hold, then consume.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].sv, vecs[v].si, vecs[v].fl, vecs[v].rdy);
            checkOutput($sformatf("vec%0d", v), vecs[v].expValid, vecs[v].chkData,
                        vecs[v].expOut, vecs[v].expOvf);
        end

        // Flush mid-word: the three stale bits and the bit on the flush edge must vanish.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_edge", 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 2 || i == 3 || i == 4 || i == 5), 1'b0, 1'b0);
            checkOutput("flush_word", (i == 7), (i == 7), 8'h3C, 1'b0);
        end

        // Overflow: second word dropped, first kept; flush leaves holding stage alone.
        doReset();
        sendByte(8'h11, 1'b0);
        checkOutput("ovf_first", 1'b1, 1'b1, 8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        checkOutput("ovf_drop", 1'b1, 1'b1, 8'h11, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("ovf_flush", 1'b1, 1'b1, 8'h11, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_consume", 1'b0, 1'b0, 8'h00, 1'b1);

        // Back-to-back streaming with the consumer always ready.
        doReset();
        for (int w = 1; w <= 3; w++) begin
            logic [7:0] b;
            b = 8'(w);
            for (int i = 0; i < 8; i++) begin
                applyStimulus(1'b0, 1'b1, b[i], 1'b0, 1'b1);
                checkOutput($sformatf("stream_w%0d_b%0d", w, i), (i == 7), (i == 7), b, 1'b0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("stream_drain", 1'b0, 1'b0, 8'h00, 1'b0);

        // Completion and consumption on the same edge.
        doReset();
        sendByte(8'h0F, 1'b0);
        checkOutput("same_first", 1'b1, 1'b1, 8'h0F, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, (i >= 4), 1'b0, 1'b0);
        checkOutput("same_hold", 1'b1, 1'b1, 8'h0F, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("same_edge", 1'b1, 1'b1, 8'hF0, 1'b0);

        // Reset mid-word has priority over a valid bit and drops the partial word.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("midreset", 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 0 || i == 7), 1'b0, 1'b0);
            checkOutput("after_reset", (i == 7), (i == 7), 8'h81, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
